// File: rtl/idelay_pkg.sv
// Shared types for the IDELAYE2 tap controller and the delay-line test tops.
package idelay_pkg;

  localparam int TAP_W_DEF = 5;

  typedef logic [TAP_W_DEF-1:0] tap_t;

  typedef enum logic [2:0] {
    S_WAIT_RDY,
    S_INIT,
    S_IDLE,
    S_STEP,
    S_LOAD,
    S_SETTLE,
    S_VERIFY
  } state_e;

  // Where SETTLE hands control back to once the delay line has settled.
  typedef enum logic [1:0] {
    RET_IDLE,
    RET_STEP,
    RET_VERIFY
  } ret_e;

endpackage

// File: rtl/idelay_tap_ctrl_rdy_sync.sv
// Two-flop synchronizer for the asynchronous IDELAYCTRL RDY input.
module rdy_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] r_sync;

  // Shift the async level through two flops; cleared to "not ready" on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], i_async};
  end

  assign o_sync = r_sync[1];

endmodule

// File: rtl/idelay_tap_ctrl.sv
// IDELAYE2 variable-tap controller: steps or loads the delay line to a
// requested tap, settles after every change, then checks CNTVALUEOUT.
// All outputs are registered from the next-state logic, so the strobe for
// a state is visible in the same cycle the state register holds it.
module idelay_tap_ctrl
  import idelay_pkg::*;
#(
  parameter int TAP_W         = TAP_W_DEF,
  parameter int MAX_TAP       = 31,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_rdy,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAP_W-1:0] req_tap,
  input  logic             req_load,
  output logic             done,
  output logic             busy,
  output logic [TAP_W-1:0] cur_tap,
  output logic             err,
  output logic             dly_ce,
  output logic             dly_inc,
  output logic             dly_ld,
  output logic [TAP_W-1:0] dly_cntvaluein,
  input  logic [TAP_W-1:0] dly_cntvalueout
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TAP_W-1:0] MAX_T = TAP_W'(MAX_TAP);

  state_e             r_state, w_state_n;
  ret_e               r_ret, w_ret_n;
  logic [TAP_W-1:0]   r_tgt, w_tgt_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [TAP_W-1:0]   w_cur_n, w_cvin_n, w_clamp, w_eval_tgt;
  logic               w_ce_n, w_inc_n, w_ld_n, w_done_n, w_err_n;
  logic               w_go_step, w_go_verify, w_rdy, w_servicing;

  rdy_sync u_rdy_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(ctrl_rdy),
    .o_sync (w_rdy)
  );

  assign w_clamp     = (req_tap > MAX_T) ? MAX_T : req_tap;
  // In IDLE the target is being latched this cycle, so step from the fresh value.
  assign w_eval_tgt  = (r_state == S_IDLE) ? w_clamp : r_tgt;
  assign w_servicing = (r_state == S_STEP) || (r_state == S_LOAD) ||
                       ((r_state == S_SETTLE) && (r_ret != RET_IDLE));

  // Next state plus next values of every registered output.
  always_comb begin
    w_state_n   = r_state;
    w_ret_n     = r_ret;
    w_tgt_n     = r_tgt;
    w_cnt_n     = r_cnt;
    w_cur_n     = cur_tap;
    w_ce_n      = 1'b0;
    w_inc_n     = 1'b0;
    w_ld_n      = 1'b0;
    w_cvin_n    = '0;
    w_done_n    = 1'b0;
    w_err_n     = err;
    w_go_step   = 1'b0;
    w_go_verify = 1'b0;

    case (r_state)
      S_WAIT_RDY: if (w_rdy) begin
        w_state_n = S_INIT;
        w_ld_n    = 1'b1;
        w_cur_n   = '0;
        w_ret_n   = RET_IDLE;
      end
      S_IDLE: if (req_valid) begin
        w_tgt_n = w_clamp;
        if (req_load) begin
          w_state_n = S_LOAD;
          w_ld_n    = 1'b1;
          w_cvin_n  = w_clamp;
          w_cur_n   = w_clamp;
          w_ret_n   = RET_VERIFY;
        end else begin
          w_ret_n   = RET_STEP;
          w_go_step = 1'b1;
        end
      end
      S_INIT, S_STEP, S_LOAD: begin
        w_state_n = S_SETTLE;
        w_cnt_n   = '0;
      end
      S_SETTLE: begin
        if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          case (r_ret)
            RET_IDLE: w_state_n   = S_IDLE;
            RET_STEP: w_go_step   = 1'b1;
            default:  w_go_verify = 1'b1;
          endcase
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      S_VERIFY: w_state_n = S_IDLE;
      default:  w_state_n = S_WAIT_RDY;
    endcase

    // A step that is already on target costs no cycle: go straight to VERIFY.
    if (w_go_step) begin
      if (w_eval_tgt == cur_tap) begin
        w_go_verify = 1'b1;
      end else begin
        w_state_n = S_STEP;
        w_ce_n    = 1'b1;
        w_inc_n   = (w_eval_tgt > cur_tap);
        w_cur_n   = (w_eval_tgt > cur_tap) ? cur_tap + TAP_W'(1) : cur_tap - TAP_W'(1);
      end
    end

    if (w_go_verify) begin
      w_state_n = S_VERIFY;
      w_done_n  = 1'b1;
      if (dly_cntvalueout != cur_tap) w_err_n = 1'b1;
    end

    // Losing IDELAYCTRL readiness overrides everything; INIT re-zeros later.
    if (!w_rdy && (r_state != S_WAIT_RDY)) begin
      w_state_n = S_WAIT_RDY;
      w_tgt_n   = r_tgt;
      w_cur_n   = cur_tap;
      w_ce_n    = 1'b0;
      w_inc_n   = 1'b0;
      w_ld_n    = 1'b0;
      w_cvin_n  = '0;
      w_done_n  = 1'b0;
      if (w_servicing) w_err_n = 1'b1;
    end
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_WAIT_RDY;
      r_ret          <= RET_IDLE;
      r_tgt          <= '0;
      r_cnt          <= '0;
      req_ready      <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b1;
      cur_tap        <= '0;
      err            <= 1'b0;
      dly_ce         <= 1'b0;
      dly_inc        <= 1'b0;
      dly_ld         <= 1'b0;
      dly_cntvaluein <= '0;
    end else begin
      r_state        <= w_state_n;
      r_ret          <= w_ret_n;
      r_tgt          <= w_tgt_n;
      r_cnt          <= w_cnt_n;
      req_ready      <= (w_state_n == S_IDLE);
      done           <= w_done_n;
      busy           <= (w_state_n != S_IDLE);
      cur_tap        <= w_cur_n;
      err            <= w_err_n;
      dly_ce         <= w_ce_n;
      dly_inc        <= w_inc_n;
      dly_ld         <= w_ld_n;
      dly_cntvaluein <= w_cvin_n;
    end
  end

endmodule
